// File: rtl/dds_burst_scheduler.sv
// dds_burst_scheduler
// Burst sequencer in front of DDS_control: accepts a chaotic state word, derives
// the frequency word, snapshots the burst configuration, pulses the DDS restart,
// times the burst (hold-timed or truncation-driven with a watchdog) and enforces
// a guard gap before the next word can be accepted.
module dds_burst_scheduler #(
   parameter int PHASE_WIDTH      = 32,
   parameter int PERIOD_NUM_WIDTH = 3,
   parameter int HOLD_WIDTH       = 16,
   parameter int GAP_WIDTH        = 12,
   parameter int TIMEOUT_WIDTH    = 20
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        abort,
   input  logic [PHASE_WIDTH-1:0]      chaos_state,
   input  logic                        chaos_valid,
   output logic                        chaos_ready,
   input  logic [PHASE_WIDTH-1:0]      frq_base,
   input  logic [4:0]                  frq_shift,
   input  logic                        trunc_mode,
   input  logic [PERIOD_NUM_WIDTH-1:0] period_num_cfg,
   input  logic [PHASE_WIDTH-1:0]      phase_init_cfg,
   input  logic [PHASE_WIDTH-1:0]      phase_end_cfg,
   input  logic [HOLD_WIDTH-1:0]       hold_cycles,
   input  logic [GAP_WIDTH-1:0]        gap_cycles,
   input  logic                        wave_out_valid,
   output logic                        dds_restart,
   output logic [PHASE_WIDTH-1:0]      frq_word,
   output logic                        dds_mod,
   output logic [PERIOD_NUM_WIDTH-1:0] period_num,
   output logic [PHASE_WIDTH-1:0]      phase_init,
   output logic [PHASE_WIDTH-1:0]      phase_end,
   output logic                        busy,
   output logic                        burst_done,
   output logic [15:0]                 burst_cnt,
   output logic                        timeout_err
);

   // One shared cycle counter serves ARM, RUN (hold or watchdog) and GAP; it is
   // cleared on every state entry, so it only needs the widest of the three.
   localparam int CNT_HG = (HOLD_WIDTH > GAP_WIDTH) ? HOLD_WIDTH : GAP_WIDTH;
   localparam int CNT_W  = (CNT_HG > TIMEOUT_WIDTH) ? CNT_HG : TIMEOUT_WIDTH;

   // Watchdog expires on the RUN cycle whose completion makes the count 2^TW-1.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((64'd1 << TIMEOUT_WIDTH) - 64'd2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_RUN,
      S_GAP
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;

   logic [CNT_W-1:0]            r_cnt;
   logic [HOLD_WIDTH-1:0]       r_hold;
   logic [GAP_WIDTH-1:0]        r_gap;

   logic                        r_dds_restart;
   logic [PHASE_WIDTH-1:0]      r_frq_word;
   logic                        r_dds_mod;
   logic [PERIOD_NUM_WIDTH-1:0] r_period_num;
   logic [PHASE_WIDTH-1:0]      r_phase_init;
   logic [PHASE_WIDTH-1:0]      r_phase_end;
   logic                        r_burst_done;
   logic [15:0]                 r_burst_cnt;
   logic                        r_timeout_err;

   logic                        w_accept;
   logic                        w_run_ok;
   logic                        w_run_tmo;
   logic [CNT_W-1:0]            w_hold_last;
   logic [CNT_W-1:0]            w_gap_last;
   logic [PHASE_WIDTH-1:0]      w_frq_calc;

   assign chaos_ready = (r_state == S_IDLE) & enable & ~abort;
   assign w_accept    = chaos_valid & chaos_ready;
   assign busy        = (r_state != S_IDLE);

   // hold_cycles=0 behaves as a single RUN cycle
   assign w_hold_last = (r_hold == '0) ? '0 : (CNT_W'(r_hold) - CNT_W'(1));
   // only consulted when the snapshot gap is non-zero
   assign w_gap_last  = CNT_W'(r_gap) - CNT_W'(1);

   assign w_frq_calc  = frq_base + (chaos_state >> frq_shift);

   assign dds_restart = r_dds_restart;
   assign frq_word    = r_frq_word;
   assign dds_mod     = r_dds_mod;
   assign period_num  = r_period_num;
   assign phase_init  = r_phase_init;
   assign phase_end   = r_phase_end;
   assign burst_done  = r_burst_done;
   assign burst_cnt   = r_burst_cnt;
   assign timeout_err = r_timeout_err;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and burst exit qualification
   always_comb begin
      w_state_nxt = r_state;
      w_run_ok    = 1'b0;
      w_run_tmo   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = abort ? S_IDLE : S_ARM;
         end
         S_ARM: begin
            // wave_out_valid is not looked at here: DDS_control re-asserts it late
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               if (r_dds_mod) begin
                  if (!wave_out_valid) begin
                     w_run_ok = 1'b1;
                  end else if (r_cnt == WD_LAST) begin
                     w_run_tmo = 1'b1;
                  end
               end else if (r_cnt == w_hold_last) begin
                  w_run_ok = 1'b1;
               end
               if (w_run_ok || w_run_tmo) begin
                  w_state_nxt = (r_gap == '0) ? S_IDLE : S_GAP;
               end
            end
         end
         S_GAP: begin
            if (abort || (r_cnt == w_gap_last)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Per-state cycle counter, cleared whenever a state is entered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Configuration snapshot and restart pulse on word acceptance
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dds_restart <= 1'b0;
         r_frq_word    <= '0;
         r_dds_mod     <= 1'b0;
         r_period_num  <= '0;
         r_phase_init  <= '0;
         r_phase_end   <= '0;
         r_hold        <= '0;
         r_gap         <= '0;
      end else begin
         r_dds_restart <= w_accept;
         if (w_accept) begin
            r_frq_word   <= w_frq_calc;
            r_dds_mod    <= trunc_mode;
            r_period_num <= period_num_cfg;
            r_phase_init <= phase_init_cfg;
            r_phase_end  <= phase_end_cfg;
            r_hold       <= hold_cycles;
            r_gap        <= gap_cycles;
         end
      end
   end

   // Completion pulse, completed-burst count and sticky watchdog flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_burst_done  <= 1'b0;
         r_burst_cnt   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_burst_done <= w_run_ok;
         if (w_run_ok) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
         end
         if (w_run_tmo) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dds_burst_scheduler.sv
// tb_dds_burst_scheduler
// Directed bench: instance A uses the default 20-bit watchdog, instance B a 4-bit
// watchdog so that expiry is reachable in a short run. Both share all inputs.
module tb_dds_burst_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        abort;
   logic [31:0] chaos_state;
   logic        chaos_valid;
   logic [31:0] frq_base;
   logic [4:0]  frq_shift;
   logic        trunc_mode;
   logic [2:0]  period_num_cfg;
   logic [31:0] phase_init_cfg;
   logic [31:0] phase_end_cfg;
   logic [15:0] hold_cycles;
   logic [11:0] gap_cycles;
   logic        wave_out_valid;

   logic        a_chaos_ready, a_dds_restart, a_dds_mod, a_busy, a_burst_done, a_timeout_err;
   logic [31:0] a_frq_word, a_phase_init, a_phase_end;
   logic [2:0]  a_period_num;
   logic [15:0] a_burst_cnt;

   logic        b_chaos_ready, b_dds_restart, b_dds_mod, b_busy, b_burst_done, b_timeout_err;
   logic [31:0] b_frq_word, b_phase_init, b_phase_end;
   logic [2:0]  b_period_num;
   logic [15:0] b_burst_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dds_burst_scheduler u_dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
      .chaos_state(chaos_state), .chaos_valid(chaos_valid), .chaos_ready(a_chaos_ready),
      .frq_base(frq_base), .frq_shift(frq_shift), .trunc_mode(trunc_mode),
      .period_num_cfg(period_num_cfg), .phase_init_cfg(phase_init_cfg),
      .phase_end_cfg(phase_end_cfg), .hold_cycles(hold_cycles), .gap_cycles(gap_cycles),
      .wave_out_valid(wave_out_valid), .dds_restart(a_dds_restart), .frq_word(a_frq_word),
      .dds_mod(a_dds_mod), .period_num(a_period_num), .phase_init(a_phase_init),
      .phase_end(a_phase_end), .busy(a_busy), .burst_done(a_burst_done),
      .burst_cnt(a_burst_cnt), .timeout_err(a_timeout_err)
   );

   dds_burst_scheduler #(.TIMEOUT_WIDTH(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
      .chaos_state(chaos_state), .chaos_valid(chaos_valid), .chaos_ready(b_chaos_ready),
      .frq_base(frq_base), .frq_shift(frq_shift), .trunc_mode(trunc_mode),
      .period_num_cfg(period_num_cfg), .phase_init_cfg(phase_init_cfg),
      .phase_end_cfg(phase_end_cfg), .hold_cycles(hold_cycles), .gap_cycles(gap_cycles),
      .wave_out_valid(wave_out_valid), .dds_restart(b_dds_restart), .frq_word(b_frq_word),
      .dds_mod(b_dds_mod), .period_num(b_period_num), .phase_init(b_phase_init),
      .phase_end(b_phase_end), .busy(b_busy), .burst_done(b_burst_done),
      .burst_cnt(b_burst_cnt), .timeout_err(b_timeout_err)
   );

   // advance one clock, land just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [31:0] cs, input logic [31:0] fb, input logic [4:0] sh,
                          input logic tm, input logic [2:0] pn, input logic [31:0] pi,
                          input logic [31:0] pe, input logic [15:0] hc, input logic [11:0] gc);
      chaos_state    = cs;
      frq_base       = fb;
      frq_shift      = sh;
      trunc_mode     = tm;
      period_num_cfg = pn;
      phase_init_cfg = pi;
      phase_end_cfg  = pe;
      hold_cycles    = hc;
      gap_cycles     = gc;
   endtask

   // present a word for one edge (cycle T); returns positioned in T+1
   task automatic fire();
      chaos_valid = 1'b1;
      tick();
      chaos_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; abort = 1'b0; chaos_valid = 1'b0; wave_out_valid = 1'b1;
      set_cfg(32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0, 12'd0);
      tick();
      tick();
      n_tests++; if (a_dds_restart !== 1'b0) begin n_fail++; $display("FAIL rst_restart: got %b want 0", a_dds_restart); end
      n_tests++; if (a_frq_word !== 32'h0) begin n_fail++; $display("FAIL rst_frq: got %h want 0", a_frq_word); end
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
      n_tests++; if (a_burst_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", a_burst_cnt); end
      n_tests++; if (a_timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b want 0", a_timeout_err); end
      n_tests++; if (a_burst_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", a_burst_done); end
      rst_n = 1'b1;
      tick();
      n_tests++; if (a_chaos_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_disabled: got %b want 0", a_chaos_ready); end
      enable = 1'b1;
      #1;
      n_tests++; if (a_chaos_ready !== 1'b1) begin n_fail++; $display("FAIL rdy_enabled: got %b want 1", a_chaos_ready); end
      abort = 1'b1;
      #1;
      n_tests++; if (a_chaos_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_abort: got %b want 0", a_chaos_ready); end
      abort = 1'b0;
   endtask

   task automatic test_accept_hold();
      set_cfg(32'h0000_1000, 32'h100, 5'd4, 1'b0, 3'd3, 32'h1111_1111, 32'h2222_2222, 16'd5, 12'd3);
      chaos_valid = 1'b1;
      #1;
      n_tests++; if (a_chaos_ready !== 1'b1) begin n_fail++; $display("FAIL acc_ready_T: got %b want 1", a_chaos_ready); end
      fire();
      // scramble inputs mid-burst: snapshot must not move
      set_cfg(32'hDEAD_BEEF, 32'h5555, 5'd1, 1'b1, 3'd7, 32'h3, 32'h4, 16'd2, 12'd1);
      n_tests++; if (a_dds_restart !== 1'b1) begin n_fail++; $display("FAIL acc_restart_T1: got %b want 1", a_dds_restart); end
      n_tests++; if (a_frq_word !== 32'h200) begin n_fail++; $display("FAIL acc_frq: got %h want 00000200", a_frq_word); end
      n_tests++; if (a_dds_mod !== 1'b0) begin n_fail++; $display("FAIL acc_mod: got %b want 0", a_dds_mod); end
      n_tests++; if (a_period_num !== 3'd3) begin n_fail++; $display("FAIL acc_period: got %0d want 3", a_period_num); end
      n_tests++; if (a_phase_init !== 32'h1111_1111) begin n_fail++; $display("FAIL acc_pinit: got %h want 11111111", a_phase_init); end
      n_tests++; if (a_phase_end !== 32'h2222_2222) begin n_fail++; $display("FAIL acc_pend: got %h want 22222222", a_phase_end); end
      n_tests++; if (a_chaos_ready !== 1'b0) begin n_fail++; $display("FAIL acc_ready_T1: got %b want 0", a_chaos_ready); end
      for (int c = 2; c <= 12; c++) begin
         tick();
         n_tests++; if (a_dds_restart !== 1'b0) begin n_fail++; $display("FAIL hold_restart_c%0d: got %b want 0", c, a_dds_restart); end
         n_tests++; if (a_burst_done !== (c == 9)) begin n_fail++; $display("FAIL hold_done_c%0d: got %b want %b", c, a_burst_done, (c == 9)); end
         n_tests++; if (a_busy !== (c <= 11)) begin n_fail++; $display("FAIL hold_busy_c%0d: got %b want %b", c, a_busy, (c <= 11)); end
         n_tests++; if (a_chaos_ready !== (c == 12)) begin n_fail++; $display("FAIL hold_ready_c%0d: got %b want %b", c, a_chaos_ready, (c == 12)); end
      end
      n_tests++; if (a_burst_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_cnt: got %0d want 1", a_burst_cnt); end
      n_tests++; if (a_frq_word !== 32'h200) begin n_fail++; $display("FAIL hold_frq_kept: got %h want 00000200", a_frq_word); end
      n_tests++; if (a_dds_mod !== 1'b0) begin n_fail++; $display("FAIL hold_mod_kept: got %b want 0", a_dds_mod); end
   endtask

   task automatic test_frq_wrap();
      // hold_cycles=0 -> one RUN cycle; gap_cycles=0 -> RUN straight to IDLE
      set_cfg(32'h20, 32'hFFFF_FFF0, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0, 12'd0);
      fire();
      n_tests++; if (a_frq_word !== 32'h10) begin n_fail++; $display("FAIL wrap_frq: got %h want 00000010", a_frq_word); end
      n_tests++; if (a_dds_restart !== 1'b1) begin n_fail++; $display("FAIL wrap_restart: got %b want 1", a_dds_restart); end
      for (int c = 2; c <= 5; c++) begin
         tick();
         n_tests++; if (a_busy !== (c <= 4)) begin n_fail++; $display("FAIL wrap_busy_c%0d: got %b want %b", c, a_busy, (c <= 4)); end
         n_tests++; if (a_burst_done !== (c == 5)) begin n_fail++; $display("FAIL wrap_done_c%0d: got %b want %b", c, a_burst_done, (c == 5)); end
      end
      n_tests++; if (a_burst_cnt !== 16'd2) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 2", a_burst_cnt); end
      n_tests++; if (a_chaos_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready: got %b want 1", a_chaos_ready); end
   endtask

   task automatic test_trunc_wave();
      set_cfg(32'h0, 32'h1234, 5'd0, 1'b1, 3'd5, 32'hA, 32'hB, 16'd3, 12'd2);
      wave_out_valid = 1'b1;
      fire();
      n_tests++; if (a_dds_mod !== 1'b1) begin n_fail++; $display("FAIL trunc_mod: got %b want 1", a_dds_mod); end
      n_tests++; if (a_period_num !== 3'd5) begin n_fail++; $display("FAIL trunc_period: got %0d want 5", a_period_num); end
      for (int c = 2; c <= 23; c++) begin
         tick();
         wave_out_valid = !((c == 2) || (c == 20));
         n_tests++; if (a_burst_done !== (c == 21)) begin n_fail++; $display("FAIL trunc_done_c%0d: got %b want %b", c, a_burst_done, (c == 21)); end
         n_tests++; if (a_busy !== (c <= 22)) begin n_fail++; $display("FAIL trunc_busy_c%0d: got %b want %b", c, a_busy, (c <= 22)); end
      end
      wave_out_valid = 1'b1;
      n_tests++; if (a_burst_cnt !== 16'd3) begin n_fail++; $display("FAIL trunc_cnt: got %0d want 3", a_burst_cnt); end
      n_tests++; if (a_timeout_err !== 1'b0) begin n_fail++; $display("FAIL trunc_tmo: got %b want 0", a_timeout_err); end
   endtask

   task automatic test_timeout();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_cfg(32'h1, 32'h1, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd1, 12'd0);
      fire();
      for (int c = 2; c <= 5; c++) tick();
      n_tests++; if (b_burst_cnt !== 16'd1) begin n_fail++; $display("FAIL tmo_pre_cnt: got %0d want 1", b_burst_cnt); end
      set_cfg(32'h1, 32'h1, 5'd0, 1'b1, 3'd2, 32'h0, 32'h0, 16'd0, 12'd0);
      wave_out_valid = 1'b1;
      fire();
      for (int c = 2; c <= 19; c++) begin
         tick();
         n_tests++; if (b_busy !== (c <= 18)) begin n_fail++; $display("FAIL tmo_busy_c%0d: got %b want %b", c, b_busy, (c <= 18)); end
         n_tests++; if (b_timeout_err !== (c == 19)) begin n_fail++; $display("FAIL tmo_err_c%0d: got %b want %b", c, b_timeout_err, (c == 19)); end
         n_tests++; if (b_burst_done !== 1'b0) begin n_fail++; $display("FAIL tmo_done_c%0d: got %b want 0", c, b_burst_done); end
      end
      n_tests++; if (b_burst_cnt !== 16'd1) begin n_fail++; $display("FAIL tmo_cnt: got %0d want 1", b_burst_cnt); end
      n_tests++; if (a_timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_wide_err: got %b want 0", a_timeout_err); end
      n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_wide_busy: got %b want 1", a_busy); end
      tick();
      n_tests++; if (b_timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", b_timeout_err); end
      // A is still running on its long watchdog: abort it
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_abort_busy: got %b want 0", a_busy); end
      n_tests++; if (a_burst_done !== 1'b0) begin n_fail++; $display("FAIL tmo_abort_done: got %b want 0", a_burst_done); end
      n_tests++; if (a_burst_cnt !== 16'd1) begin n_fail++; $display("FAIL tmo_abort_cnt: got %0d want 1", a_burst_cnt); end
   endtask

   task automatic test_abort();
      set_cfg(32'h40, 32'h0, 5'd2, 1'b0, 3'd1, 32'h5, 32'h6, 16'd10, 12'd4);
      fire();
      for (int c = 2; c <= 5; c++) tick();
      n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", a_busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", a_busy); end
      n_tests++; if (a_dds_restart !== 1'b0) begin n_fail++; $display("FAIL abort_restart: got %b want 0", a_dds_restart); end
      n_tests++; if (a_frq_word !== 32'h10) begin n_fail++; $display("FAIL abort_frq_held: got %h want 00000010", a_frq_word); end
      n_tests++; if (a_period_num !== 3'd1) begin n_fail++; $display("FAIL abort_period_held: got %0d want 1", a_period_num); end
      for (int c = 6; c <= 9; c++) begin
         n_tests++; if (a_burst_done !== 1'b0) begin n_fail++; $display("FAIL abort_done_c%0d: got %b want 0", c, a_burst_done); end
         tick();
      end
      n_tests++; if (a_burst_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_cnt: got %0d want 1", a_burst_cnt); end
   endtask

   task automatic test_enable_midburst();
      set_cfg(32'h8, 32'h2, 5'd3, 1'b0, 3'd4, 32'h1, 32'h2, 16'd2, 12'd1);
      fire();
      enable = 1'b0;
      for (int c = 2; c <= 7; c++) begin
         tick();
         n_tests++; if (a_burst_done !== (c == 6)) begin n_fail++; $display("FAIL en_done_c%0d: got %b want %b", c, a_burst_done, (c == 6)); end
         n_tests++; if (a_busy !== (c <= 6)) begin n_fail++; $display("FAIL en_busy_c%0d: got %b want %b", c, a_busy, (c <= 6)); end
      end
      n_tests++; if (a_burst_cnt !== 16'd2) begin n_fail++; $display("FAIL en_cnt: got %0d want 2", a_burst_cnt); end
      chaos_valid = 1'b1;
      #1;
      n_tests++; if (a_chaos_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready_blocked: got %b want 0", a_chaos_ready); end
      tick();
      chaos_valid = 1'b0;
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL en_no_accept: got %b want 0", a_busy); end
      enable = 1'b1;
      #1;
      n_tests++; if (a_chaos_ready !== 1'b1) begin n_fail++; $display("FAIL en_ready_back: got %b want 1", a_chaos_ready); end
   endtask

   task automatic test_reset_mid_gap();
      set_cfg(32'h100, 32'h1, 5'd8, 1'b1, 3'd6, 32'h7, 32'h9, 16'd0, 12'd5);
      wave_out_valid = 1'b0;
      fire();
      for (int c = 2; c <= 6; c++) begin
         tick();
         n_tests++; if (a_burst_done !== (c == 5)) begin n_fail++; $display("FAIL rg_done_c%0d: got %b want %b", c, a_burst_done, (c == 5)); end
      end
      n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rg_gap_busy: got %b want 1", a_busy); end
      n_tests++; if (a_burst_cnt !== 16'd3) begin n_fail++; $display("FAIL rg_cnt: got %0d want 3", a_burst_cnt); end
      n_tests++; if (a_frq_word !== 32'h2) begin n_fail++; $display("FAIL rg_frq: got %h want 00000002", a_frq_word); end
      n_tests++; if (b_timeout_err !== 1'b1) begin n_fail++; $display("FAIL rg_tmo_pre: got %b want 1", b_timeout_err); end
      rst_n = 1'b0;
      tick();
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rg_busy: got %b want 0", a_busy); end
      n_tests++; if (a_frq_word !== 32'h0) begin n_fail++; $display("FAIL rg_frq0: got %h want 0", a_frq_word); end
      n_tests++; if (a_dds_mod !== 1'b0) begin n_fail++; $display("FAIL rg_mod0: got %b want 0", a_dds_mod); end
      n_tests++; if (a_period_num !== 3'd0) begin n_fail++; $display("FAIL rg_period0: got %0d want 0", a_period_num); end
      n_tests++; if (a_phase_init !== 32'h0) begin n_fail++; $display("FAIL rg_pinit0: got %h want 0", a_phase_init); end
      n_tests++; if (a_phase_end !== 32'h0) begin n_fail++; $display("FAIL rg_pend0: got %h want 0", a_phase_end); end
      n_tests++; if (a_burst_cnt !== 16'h0) begin n_fail++; $display("FAIL rg_cnt0: got %0d want 0", a_burst_cnt); end
      n_tests++; if (a_dds_restart !== 1'b0) begin n_fail++; $display("FAIL rg_restart0: got %b want 0", a_dds_restart); end
      n_tests++; if (b_timeout_err !== 1'b0) begin n_fail++; $display("FAIL rg_tmo0: got %b want 0", b_timeout_err); end
      rst_n = 1'b1;
      wave_out_valid = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: bench still running at %0t", $time);
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_accept_hold();
      test_frq_wrap();
      test_trunc_wave();
      test_timeout();
      test_abort();
      test_enable_midburst();
      test_reset_mid_gap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
